// File: rtl/udma_uart_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udma_uart_rx_ctrl_pkg
//  Description : Shared types and constants for the UART RX controller:
//                idle-timeout scheduler state encoding and the saturation
//                value of the optional dropped-character counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package udma_uart_rx_ctrl_pkg;

    // Idle-timeout scheduler states.
    typedef enum logic [1:0] {
        TO_IDLE  = 2'd0,
        TO_ARMED = 2'd1,
        TO_FIRED = 2'd2
    } to_state_e;

    // Saturation value of the dropped-character counter.
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage : udma_uart_rx_ctrl_pkg
`default_nettype wire

// File: rtl/udma_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : udma_uart_rx_fifo
//  Description : Synchronous FIFO with registered pointers, registered level
//                and synchronous flush. The head entry is presented from the
//                storage array addressed by the registered read pointer, so
//                a push becomes visible one cycle later (no bypass).
//  Ports       : clk_i/rstn_i  clock, async active-low reset
//                flush_i       empties the FIFO on the next edge (wins)
//                push_i/data_i write request and data (ignored when full)
//                pop_i         read request (ignored when empty)
//                data_o        head entry
//                full_o/empty_o/level_o  status from the registered level
//  Revision    : 1.0 - initial release
// ============================================================================
module udma_uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                // DEPTH is a power of two, so the pointer wraps naturally.
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule : udma_uart_rx_fifo
`default_nettype wire

// File: rtl/udma_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : udma_uart_rx_ctrl
//  Description : UART RX controller between the deserialiser and the uDMA RX
//                channel. Buffers characters in a FIFO, drives RTS from a
//                fill threshold, flags a partially filled buffer after an
//                idle timeout and reports characters dropped on overflow.
//  Options     : `define UDMA_UART_RX_CTRL_DROP_CNT_EN to build the 16-bit
//                saturating dropped-character counter (drop_cnt_o,
//                cfg_drop_clr_i). Without it drop_cnt_o reads 0.
//  Ports       : clk_i, rstn_i          clock, async active-low reset
//                cfg_en_i               enable; low flushes and idles
//                cfg_rts_en_i/_thr_i    RTS enable and level threshold
//                cfg_timeout_i          idle timeout in cycles (0 = off)
//                rx_data_i/rx_valid_i   character strobe from deserialiser
//                rx_ready_o             not full
//                rx_busy_i              deserialiser mid-frame
//                dma_data_o/valid_o/ready_i  FIFO head handshake
//                rts_o                  1 = ask sender to stop
//                fifo_level_o           occupancy
//                irq_timeout_o          single-cycle idle-timeout pulse
//                err_drop_o             single-cycle dropped-char pulse
//                drop_cnt_o/cfg_drop_clr_i  dropped-char counter and clear
//  Revision    : 1.0 - initial release
// ============================================================================
module udma_uart_rx_ctrl
    import udma_uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TO_WIDTH   = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cfg_en_i,
    input  logic                cfg_rts_en_i,
    input  logic [LVL_W-1:0]    cfg_rts_thr_i,
    input  logic [TO_WIDTH-1:0] cfg_timeout_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    input  logic                rx_busy_i,
    output logic [7:0]          dma_data_o,
    output logic                dma_valid_o,
    input  logic                dma_ready_i,
    output logic                rts_o,
    output logic [LVL_W-1:0]    fifo_level_o,
    output logic                irq_timeout_o,
    output logic                err_drop_o,
    output logic [15:0]         drop_cnt_o,
    input  logic                cfg_drop_clr_i
);

    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    logic push;
    logic pop;
    logic drop;

    logic rts_q, rts_d;
    logic irq_q, irq_d;
    logic err_drop_q, err_drop_d;

    to_state_e         to_state_q, to_state_d;
    logic [TO_WIDTH-1:0] idle_cnt_q, idle_cnt_d;

    // All accepted traffic is gated by the enable; full is the registered
    // flag, so a pop in the same cycle never makes room for a push.
    assign push = cfg_en_i && rx_valid_i && !fifo_full;
    assign drop = cfg_en_i && rx_valid_i && fifo_full;
    assign pop  = cfg_en_i && !fifo_empty && dma_ready_i;

    udma_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (!cfg_en_i),
        .push_i  (push),
        .data_i  (rx_data_i),
        .pop_i   (pop),
        .data_o  (dma_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign rx_ready_o    = !fifo_full;
    assign dma_valid_o   = !fifo_empty;
    assign fifo_level_o  = fifo_level;
    assign rts_o         = rts_q;
    assign irq_timeout_o = irq_q;
    assign err_drop_o    = err_drop_q;

    // RTS follows the registered level with one cycle of lag.
    always_comb begin
        rts_d      = cfg_rts_en_i && (fifo_level >= cfg_rts_thr_i);
        err_drop_d = drop;
    end

    // Idle-timeout scheduler: at most one irq per quiet period.
    always_comb begin
        to_state_d = to_state_q;
        idle_cnt_d = idle_cnt_q;
        irq_d      = 1'b0;
        if (!cfg_en_i) begin
            to_state_d = TO_IDLE;
            idle_cnt_d = '0;
        end else begin
            case (to_state_q)
                TO_IDLE: begin
                    idle_cnt_d = '0;
                    if (push && (cfg_timeout_i != '0)) begin
                        to_state_d = TO_ARMED;
                    end
                end
                TO_ARMED: begin
                    if (cfg_timeout_i == '0) begin
                        to_state_d = TO_IDLE;
                        idle_cnt_d = '0;
                    end else if (fifo_empty && !push) begin
                        to_state_d = TO_IDLE;
                        idle_cnt_d = '0;
                    end else if (push || pop || rx_busy_i) begin
                        // Line activity restarts the quiet period.
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == (cfg_timeout_i - TO_WIDTH'(1))) begin
                        irq_d      = 1'b1;
                        to_state_d = TO_FIRED;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + TO_WIDTH'(1);
                    end
                end
                TO_FIRED: begin
                    if (push) begin
                        to_state_d = TO_ARMED;
                        idle_cnt_d = '0;
                    end else if (fifo_empty) begin
                        to_state_d = TO_IDLE;
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    to_state_d = TO_IDLE;
                    idle_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rts_q      <= 1'b0;
            irq_q      <= 1'b0;
            err_drop_q <= 1'b0;
            to_state_q <= TO_IDLE;
            idle_cnt_q <= '0;
        end else begin
            rts_q      <= rts_d;
            irq_q      <= irq_d;
            err_drop_q <= err_drop_d;
            to_state_q <= to_state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

`ifdef UDMA_UART_RX_CTRL_DROP_CNT_EN
    // Saturating count of dropped characters; survives cfg_en_i low.
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (cfg_drop_clr_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_drop_clr;
    assign unused_drop_clr = cfg_drop_clr_i;
    assign drop_cnt_o      = '0;
`endif

endmodule : udma_uart_rx_ctrl
`default_nettype wire

// File: doc/udma_uart_rx_ctrl.md
Name: udma_uart_rx_ctrl

Overview:
- Sits between the UART RX deserialiser (udma_uart_rx) and the uDMA RX channel.
- Buffers received characters in a small FIFO and generates RTS flow control from a fill threshold.
- Runs an idle-timeout scheduler that flags a partial buffer to software when the line goes quiet.
- Reports dropped characters when the deserialiser presents a character while the buffer is full.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, >= 2
TO_WIDTH, 16, width of the timeout counter and cfg_timeout_i
LVL_W, $clog2(FIFO_DEPTH)+1, derived width of level and threshold signals; not overridable

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset
cfg_en_i  in  1  block enable; low flushes FIFO and idles the scheduler
cfg_rts_en_i  in  1  RTS generation enable
cfg_rts_thr_i  in  LVL_W  level at or above which rts_o asserts (stop sender)
cfg_timeout_i  in  TO_WIDTH  idle timeout in clk cycles; 0 disables
rx_data_i  in  8  character from deserialiser
rx_valid_i  in  1  single-cycle character strobe from deserialiser
rx_ready_o  out  1  = !full; fed to deserialiser for overflow reporting
rx_busy_i  in  1  deserialiser mid-frame
dma_data_o  out  8  FIFO head
dma_valid_o  out  1  FIFO non-empty
dma_ready_i  in  1  uDMA accepts head
rts_o  out  1  1 = request sender to stop
fifo_level_o  out  LVL_W  current occupancy
irq_timeout_o  out  1  single-cycle timeout pulse
err_drop_o  out  1  single-cycle pulse: character dropped
drop_cnt_o  out  16  dropped-character count (optional feature)
cfg_drop_clr_i  in  1  clears drop_cnt_o (optional feature)

Behaviour:
- Reset and clock: single clock clk_i; reset rstn_i is asynchronous, active-low.
- Reset values: all outputs 0, except rx_ready_o = 1 (empty and not full). FIFO empty, scheduler in TO_IDLE.
- Push: rx_valid_i && !full writes rx_data_i.
- Drop: rx_valid_i && full drops the character, pulses err_drop_o and leaves the FIFO unchanged. A pop in the same cycle does not rescue the push; rx_ready_o is registered-full based.
- Pop: dma_valid_o && dma_ready_i. dma_data_o is stable while dma_valid_o is high and not popped.
- Latency: a push at cycle N gives dma_valid_o/data at N+1. No combinational bypass.
- Simultaneous push and pop: level unchanged; valid at any level except full, where only the pop occurs.
- Pointers: wrap modulo FIFO_DEPTH.
- Level: fifo_level_o is 0..FIFO_DEPTH and is registered.
- RTS: rts_o = cfg_rts_en_i && (fifo_level_o >= cfg_rts_thr_i), registered, 1-cycle lag from level. cfg_rts_thr_i = 0 with cfg_rts_en_i high holds rts_o = 1.
- cfg_en_i low: FIFO flushes (level 0) on the next edge, scheduler goes to TO_IDLE, counter clears, and no pulses are issued. Inputs are ignored while low.
- Timeout scheduler, 16-bit-wide counter idle_cnt:
  - TO_IDLE: wait for a push with cfg_timeout_i != 0, then go to TO_ARMED with idle_cnt = 0.
  - TO_ARMED: idle_cnt clears on push, pop, or rx_busy_i; otherwise it increments.
    - If idle_cnt == cfg_timeout_i-1 with FIFO non-empty: pulse irq_timeout_o and go to TO_FIRED.
    - If FIFO empty: go to TO_IDLE.
    - If cfg_timeout_i becomes 0: go to TO_IDLE.
  - TO_FIRED: a push goes to TO_ARMED (counter 0); FIFO empty goes to TO_IDLE. At most one irq per quiet period.
- The counter never wraps; it holds while comparing in TO_ARMED.

Optional Feature:
- Macro: UDMA_UART_RX_CTRL_DROP_CNT_EN.
- Defined:
  - drop_cnt_o is a 16-bit saturating counter (sticks at 0xFFFF) incremented on each err_drop_o.
  - cfg_drop_clr_i clears it synchronously; clear wins over increment.
  - The counter is not cleared by cfg_en_i.
- Undefined: drop_cnt_o tied to 0 and cfg_drop_clr_i ignored; ports remain present.

Decomposition:
- Package udma_uart_rx_ctrl_pkg holds:
  - Scheduler enum {TO_IDLE, TO_ARMED, TO_FIRED} (logic [1:0]).
  - DROP_CNT_MAX constant, 16'hFFFF.
- Sub-module udma_uart_rx_fifo (DEPTH, WIDTH=8): registered-output sync FIFO with push/pop/full/empty/level and synchronous flush.

Test Plan:
- Push 0xA5 at cycle 10 with dma_ready_i=0 -> dma_valid_o=1, dma_data_o=0xA5 at cycle 11, held until ready; pop -> level 0, dma_valid_o=0 next cycle.
- DEPTH=8: push 9 chars, no pops -> rx_ready_o=0 after the 8th; 9th gives err_drop_o pulse, level stays 8; drop_cnt_o=1 with the macro, 0 without.
- cfg_rts_en_i=1, cfg_rts_thr_i=4: push 4 -> rts_o=1 one cycle after level reaches 4; pop 1 -> rts_o=0 one cycle after level 3.
- cfg_timeout_i=20: push 1 char, then idle -> irq_timeout_o pulse exactly 20 cycles after the push edge, state TO_FIRED. No second pulse over 100 further cycles. A new push re-arms and the next pulse comes 20 cycles later.
- rx_busy_i held high for 50 cycles with a char buffered, cfg_timeout_i=20 -> no irq. Busy falls -> irq 20 cycles later.
- FIFO holding 5 chars: drop cfg_en_i for 1 cycle -> level 0, dma_valid_o=0, state TO_IDLE, no irq. Assert rstn_i low mid-operation -> all outputs at reset values asynchronously.
